// File: rtl/pipe_stage_chain_pkg.sv
// Shared sizing helper and skid-slot state encoding for pipe_stage_chain and pipe_stage.
// The ONE/TWO states are only used when PIPE_SKID_EN is defined.
package pipe_stage_chain_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_e;

    // Wide enough for the skid build's 2*DEPTH entries, so both builds share one port width.
    function automatic int occ_width(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_chain_pipe_stage.sv
// One valid/ready register slice of pipe_stage_chain.
// PIPE_SKID_EN adds a skid slot and makes in_ready a pure function of registered state.
module pipe_stage
    import pipe_stage_chain_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

`ifdef PIPE_SKID_EN
    stage_state_e      state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              push;
    logic              pop;

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_d = in_data;
                    end else if (push) begin
                        state_d = TWO;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = EMPTY;
                        main_d  = NOP_VALUE;
                    end
                end
                TWO: begin
                    // Ready was low this cycle, so only a pop can happen here.
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = NOP_VALUE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = NOP_VALUE;
                    skid_d  = NOP_VALUE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end
`else
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    assign in_ready  = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
            data_d  = NOP_VALUE;
        end else if (in_ready) begin
            valid_d = in_valid;
            data_d  = in_valid ? in_data : NOP_VALUE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= NOP_VALUE;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
`endif

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH-stage valid/ready pipeline with flush and an occupancy count.
// Define PIPE_SKID_EN to give every stage a skid slot (capacity 2*DEPTH, registered ready).
module pipe_stage_chain
    import pipe_stage_chain_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 2,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic [occ_width(DEPTH)-1:0]   occupancy
);

    localparam int OCC_W = occ_width(DEPTH);

    logic             head_valid;
    logic             head_ready;
    logic             init_q, init_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             accept;
    logic             deliver;

    // init_q holds in_ready low until the first edge after reset releases.
    assign in_ready   = init_q & ~flush & head_ready;
    assign head_valid = in_valid & init_q & ~flush;
    assign accept     = in_valid & in_ready;
    assign deliver    = out_valid & out_ready;
    assign occupancy  = occ_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic              up_valid;
        logic              up_ready;
        logic [DATA_W-1:0] up_data;
        logic              dn_valid;
        logic              dn_ready;
        logic [DATA_W-1:0] dn_data;

        if (i == 0) begin : g_head
            assign up_valid = head_valid;
            assign up_data  = in_data;
        end else begin : g_body
            assign up_valid = g_stage[i-1].dn_valid;
            assign up_data  = g_stage[i-1].dn_data;
        end

        if (i == DEPTH - 1) begin : g_tail
            assign dn_ready = out_ready;
        end else begin : g_link
            assign dn_ready = g_stage[i+1].up_ready;
        end

        pipe_stage #(
            .DATA_W    (DATA_W),
            .NOP_VALUE (NOP_VALUE)
        ) u_stage (
            .clock     (clock),
            .reset_n   (reset_n),
            .flush     (flush),
            .in_valid  (up_valid),
            .in_ready  (up_ready),
            .in_data   (up_data),
            .out_valid (dn_valid),
            .out_ready (dn_ready),
            .out_data  (dn_data)
        );
    end

    assign head_ready = g_stage[0].up_ready;
    assign out_valid  = g_stage[DEPTH-1].dn_valid;
    assign out_data   = g_stage[DEPTH-1].dn_data;

    always_comb begin
        init_d = 1'b1;
        occ_d  = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (accept && !deliver) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!accept && deliver) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            init_q <= 1'b0;
            occ_q  <= '0;
        end else begin
            init_q <= init_d;
            occ_q  <= occ_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain (DEPTH=3); works with or without PIPE_SKID_EN.
// A queue model of accepted-but-undelivered words is compared against the DUT every cycle.
`timescale 1ns/1ps
module tb_pipe_stage_chain;

    localparam int               DATA_W = 32;
    localparam int               DEPTH  = 3;
    localparam logic [31:0]      NOP    = 32'hDEAD_BEEF;
`ifdef PIPE_SKID_EN
    localparam int               CAP    = 2 * DEPTH;
`else
    localparam int               CAP    = DEPTH;
`endif
    localparam int               OCC_W  = $clog2(2 * DEPTH + 1);

    logic              clock     = 1'b0;
    logic              reset_n   = 1'b1;
    logic              flush     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data   = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [OCC_W-1:0]  occupancy;

    int                checks = 0;
    int                errors = 0;
    logic [31:0]       model_q[$];
    bit                model_init = 1'b0;

    logic [31:0] lat_valid [6] = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd0};
    logic [31:0] lat_data  [6] = '{NOP, NOP, 32'h11, 32'h22, 32'h33, NOP};
    logic [31:0] lat_occ   [6] = '{32'd1, 32'd2, 32'd3, 32'd2, 32'd1, 32'd0};

    always #5 clock = ~clock;

    pipe_stage_chain #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .NOP_VALUE (NOP)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic sendWord(input logic [31:0] d, input logic ordy, output bit ok);
        ok = 1'b0;
        applyStimulus(1'b1, d, ordy, 1'b0);
        for (int c = 0; c < 8 && !ok; c++) begin
            @(negedge clock);
            if (in_ready) ok = 1'b1;
            @(posedge clock);
            #1;
        end
        applyStimulus(1'b0, '0, ordy, 1'b0);
    endtask

    // Mid-cycle compare against the queue model, then advance the model by this cycle's handshakes.
    always @(negedge clock) begin
        if (!reset_n) begin
            checkOutput("rst_occ", 32'(occupancy), 32'd0);
            checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
            checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
            checkOutput("rst_out_data", out_data, NOP);
            model_q.delete();
            model_init = 1'b0;
        end else begin
            checkOutput("occ_vs_model", 32'(occupancy), 32'(model_q.size()));
            if (!out_valid) checkOutput("empty_is_nop", out_data, NOP);
            if (model_q.size() == 0) checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
            if (flush || !model_init) begin
                checkOutput("in_ready_blocked", 32'(in_ready), 32'd0);
`ifdef PIPE_SKID_EN
            end else if (model_q.size() == CAP) begin
                checkOutput("in_ready_full", 32'(in_ready), 32'd0);
`else
            end else begin
                checkOutput("in_ready_rule", 32'(in_ready), 32'((model_q.size() < CAP) || out_ready));
`endif
            end
            if (out_valid && out_ready) begin
                if (model_q.size() == 0) checkOutput("spurious_delivery", 32'(out_valid), 32'd0);
                else checkOutput("delivery_order", out_data, model_q.pop_front());
            end
            if (flush) model_q.delete();
            else if (in_valid && in_ready) model_q.push_back(in_data);
            model_init = 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          accepts;
        logic [31:0] nxt;
        bit          ok;
        bit          full;
        bit          seen;

        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        #1 reset_n = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2;
        checkOutput("reset_occ", 32'(occupancy), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_data", out_data, NOP);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        #1 reset_n = 1'b1;
        #1 checkOutput("in_ready_before_first_edge", 32'(in_ready), 32'd0);
        @(posedge clock);
        #2 checkOutput("in_ready_after_first_edge", 32'(in_ready), 32'd1);

        // Latency: 0x11,0x22,0x33 back-to-back, first word out DEPTH cycles after its accept.
        applyStimulus(1'b1, 32'h11, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clock);
            #1;
            if (k == 0) applyStimulus(1'b1, 32'h22, 1'b1, 1'b0);
            else if (k == 1) applyStimulus(1'b1, 32'h33, 1'b1, 1'b0);
            else applyStimulus(1'b0, '0, 1'b1, 1'b0);
            #1;
            checkOutput($sformatf("lat_valid_%0d", k), 32'(out_valid), lat_valid[k]);
            checkOutput($sformatf("lat_data_%0d", k), out_data, lat_data[k]);
            checkOutput($sformatf("lat_occ_%0d", k), 32'(occupancy), lat_occ[k]);
        end

        // Backpressure: continuous stream with out_ready low fills exactly CAP slots.
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        accepts = 0;
        nxt = 32'hA0;
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1'b1, nxt, 1'b0, 1'b0);
            @(negedge clock);
            if (in_ready) begin
                accepts++;
                nxt++;
            end
            @(posedge clock);
            #1;
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("bp_accepts", 32'(accepts), 32'(CAP));
        #1;
        checkOutput("bp_occ_full", 32'(occupancy), 32'(CAP));
        checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clock);
        #1 applyStimulus(1'b0, '0, 1'b1, 1'b0);
        for (int j = 0; j < CAP; j++) begin
            #1;
            checkOutput($sformatf("drain_valid_%0d", j), 32'(out_valid), 32'd1);
            checkOutput($sformatf("drain_data_%0d", j), out_data, 32'hA0 + 32'(j));
            @(posedge clock);
            #1;
        end
        #1 checkOutput("drain_done", 32'(out_valid), 32'd0);

        // Flush a full chain while a new word is offered; that word must vanish.
        @(posedge clock);
        #1;
        full = 1'b0;
        nxt = 32'hC0;
        for (int c = 0; c < 20 && !full; c++) begin
            applyStimulus(1'b1, nxt, 1'b0, 1'b0);
            @(negedge clock);
            if (in_ready) nxt++;
            else full = 1'b1;
            if (!full) begin
                @(posedge clock);
                #1;
            end
        end
        checkOutput("flush_fill_reached", 32'(full), 32'd1);
        @(posedge clock);
        #1 applyStimulus(1'b1, 32'h0000_0BAD, 1'b0, 1'b1);
        #1 checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clock);
        #1 applyStimulus(1'b0, '0, 1'b1, 1'b0);
        #1;
        checkOutput("flush_occ", 32'(occupancy), 32'd0);
        checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_out_data", out_data, NOP);
        for (int c = 0; c < 2 * CAP; c++) begin
            @(posedge clock);
            #2 checkOutput("flush_word_gone", 32'(out_valid), 32'd0);
        end

        // Asynchronous reset between edges with two entries held.
        @(posedge clock);
        #1 applyStimulus(1'b1, 32'hE1, 1'b0, 1'b0);
        @(posedge clock);
        #1 applyStimulus(1'b1, 32'hE2, 1'b0, 1'b0);
        @(posedge clock);
        #1 applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("pre_reset_occ", 32'(occupancy), 32'd2);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_rst_occ", 32'(occupancy), 32'd0);
        checkOutput("async_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("async_rst_out_data", out_data, NOP);
        checkOutput("async_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clock);
        #3 reset_n = 1'b1;
        sendWord(32'h77, 1'b1, ok);
        checkOutput("post_rst_accept", 32'(ok), 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clock);
            if (out_valid) seen = 1'b1;
        end
        checkOutput("post_rst_seen", 32'(seen), 32'd1);
        checkOutput("post_rst_first_word", out_data, 32'h77);

        // Random valid/ready/flush traffic, checked continuously by the model.
        @(posedge clock);
        #1;
        for (int c = 0; c < 10000; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 299) == 0));
            @(posedge clock);
            #1;
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        repeat (CAP + 4) @(posedge clock);
        #1;
        checkOutput("final_occ", 32'(occupancy), 32'd0);
        checkOutput("final_model_empty", 32'(model_q.size()), 32'd0);
        checkOutput("final_out_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
